// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared digit states, constants and hex-to-segment table for the scan controller
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_state_t;

    // Active-low segment patterns, seg[0]=a .. seg[6]=g, indexed by nibble value
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low seven-segment decoder
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed display scanner with tear-free double buffer; SEG_DP_EN adds dp_in
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [NUM_DIGITS-1:0] blank_in,
`ifdef SEG_DP_EN
    input  logic [NUM_DIGITS-1:0] dp_in,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    logic [31:0] count;
    logic        tick;
    logic        boundary;
    dig_state_t  state;
    dig_state_t  state_next;
    logic        pend_full;
    logic [15:0] pend_data;
    logic [15:0] active;
    logic [1:0]  slot;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;

    assign tick       = (count == SCAN_DIV - 32'd1);
    assign boundary   = tick && (state == DIG3);
    assign data_ready = ~pend_full;
    assign slot       = state;
    assign nibble     = active[{slot, 2'b00} +: 4];

    // Prescaler: one tick every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    // Digit state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= DIG0;
        end else begin
            state <= state_next;
        end
    end

    // Digit sequencing: step to the next slot only on a prescaler tick
    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                DIG0: state_next = DIG1;
                DIG1: state_next = DIG2;
                DIG2: state_next = DIG3;
                DIG3: state_next = DIG0;
            endcase
        end
    end

    // Double buffer: pending is promoted only at the frame boundary so a frame never mixes two values;
    // an accept landing on the boundary edge stays pending for the next boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_full <= 1'b0;
            pend_data <= '0;
            active    <= '0;
        end else begin
            if (boundary) begin
                if (pend_full) begin
                    active <= pend_data;
                end
                pend_full <= 1'b0;
            end
            if (data_valid && !pend_full) begin
                pend_full <= 1'b1;
                pend_data <= data_in;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Registered drive outputs, one cycle behind the digit state
    always_ff @(posedge clk) begin
        if (!reset) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (blank_in[slot]) begin
                an  <= 4'b1111;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(4'b0001 << slot);
                seg <= seg_dec;
            end
        end
    end

`ifdef SEG_DP_EN
    // Decimal point follows the same slot and latency as the segments
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp <= 1'b1;
        end else begin
            dp <= blank_in[slot] | ~dp_in[slot];
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4
module tb_seg_scan_ctrl;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] BLK = 7'b1111111;
`ifdef SEG_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int errs  = 0;
    int cyc   = 0;

    logic [6:0] f1 [0:3];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .blank_in   (blank_in),
`ifdef SEG_DP_EN
        .dp_in      (dp_in),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'(BLK));
        check({tag, "_dp"}, 32'(dp), 32'd1);
        check({tag, "_ready"}, 32'(data_ready), 32'd1);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int         slot;
        bit         blanked;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_rdy;

        f1[0] = S1; f1[1] = S2; f1[2] = S8; f1[3] = SF;
        reset      = 1'b0;
        data_in    = 16'h0;
        data_valid = 1'b0;
        blank_in   = 4'b0000;
        dp_in      = 4'b0001;

        adv();
        adv();
        check_reset_vals("rst");

        reset = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 90; k++) begin
            adv();
            slot    = ((cyc - 1) / 4) % 4;
            blanked = (cyc >= 65) && (cyc <= 80) && (slot == 2);
            if (blanked)       e_seg = BLK;
            else if (cyc <= 16) e_seg = S0;
            else if (cyc <= 48) e_seg = f1[slot];
            else               e_seg = S1;
            e_an  = blanked ? 4'b1111 : ~(4'b0001 << slot);
            e_dp  = blanked ? 1'b1 : ((DP_EN && slot == 0) ? 1'b0 : 1'b1);
            e_rdy = !(((cyc >= 3) && (cyc <= 15)) || ((cyc >= 34) && (cyc <= 47)) || (cyc >= 81));
            check("an", 32'(an), 32'(e_an));
            check("seg", 32'(seg), 32'(e_seg));
            check("dp", 32'(dp), 32'(e_dp));
            check("frame_done", 32'(frame_done), 32'((cyc % 16) == 0));
            check("data_ready", 32'(data_ready), 32'(e_rdy));

            data_valid = 1'b0;
            case (cyc)
                2:  begin data_in = 16'hF821; data_valid = 1'b1; end
                33: begin data_in = 16'h1111; data_valid = 1'b1; end
                34: begin data_in = 16'h2222; data_valid = 1'b1; end
                64: blank_in = 4'b0100;
                80: begin blank_in = 4'b0000; data_in = 16'h3333; data_valid = 1'b1; end
                default: ;
            endcase
        end

        reset = 1'b0;
        adv();
        check_reset_vals("mid_rst1");
        adv();
        check_reset_vals("mid_rst2");

        reset = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 24; k++) begin
            adv();
            slot = ((cyc - 1) / 4) % 4;
            e_an = ~(4'b0001 << slot);
            e_dp = (DP_EN && slot == 0) ? 1'b0 : 1'b1;
            check("post_an", 32'(an), 32'(e_an));
            check("post_seg", 32'(seg), 32'(S0));
            check("post_dp", 32'(dp), 32'(e_dp));
            check("post_frame_done", 32'(frame_done), 32'(cyc == 16));
            check("post_ready", 32'(data_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
